// File: rtl/channel_sampler_pkg.sv
// channel_sampler_pkg: shared trigger/FSM encodings, record size and VGA timing constants
package channel_sampler_pkg;
  localparam int DATA_SIZE_DEF = 256;
  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_TOTAL = 525;
  typedef enum logic [1:0] {TRIG_IMM = 2'b00, TRIG_RISE = 2'b01, TRIG_FALL = 2'b10, TRIG_ANY = 2'b11} trig_t;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, PUBLISH} state_t;
  function automatic logic trig_hit(input logic [1:0] m, input logic p, input logic s);
    return m == TRIG_IMM ? 1'b1 : m == TRIG_RISE ? !p && s : m == TRIG_FALL ? p && !s : p ^ s;
  endfunction
endpackage

// File: rtl/channel_sampler_prescaler.sv
// sample_prescaler: reloadable down-counter producing one tick every prescale+1 clocks
module sample_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] prescale,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = en && cnt == '0;
  // reload on arm entry or on each tick, otherwise count down while enabled
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load || tick) cnt <= prescale;
    else if (en) cnt <= cnt - W'(1);
endmodule

// File: rtl/channel_sampler.sv
// channel_sampler: triggered 1-bit capture into a record published only during vblank
module channel_sampler
  import channel_sampler_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sig_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [1:0]                trig_mode,
  input  logic                      arm,
  input  logic                      continuous,
  input  logic                      vblank,
  output logic [DATA_SIZE-1:0]      data,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = $clog2(DATA_SIZE) + 1;
  state_t state, state_n;
  logic sync1, sig_s, prev, tick, load, hit, shift;
  logic [DATA_SIZE-1:0] shreg;
  logic [CW-1:0] cnt;
  sample_prescaler #(.W(PRESCALE_WIDTH)) u_pre (
    .clk(clk), .reset(reset), .en(state != IDLE), .load(load), .prescale(prescale), .tick(tick)
  );
  assign load = state_n == ARMED && state != ARMED;
  assign hit = trig_hit(trig_mode, prev, sig_s);
  assign shift = tick && ((state == ARMED && hit) || state == CAPTURE);
  assign busy = state != IDLE;
  // two-flop synchronizer for the asynchronous probe
  always_ff @(posedge clk)
    if (reset) {sig_s, sync1} <= 2'b00;
    else {sig_s, sync1} <= {sync1, sig_in};
  // next state and the publish strobe
  always_comb begin
    state_n = state;
    done = 1'b0;
    case (state)
      IDLE:    state_n = arm ? ARMED : IDLE;
      ARMED:   state_n = tick && hit ? CAPTURE : ARMED;
      CAPTURE: state_n = tick && cnt == CW'(DATA_SIZE - 1) ? PUBLISH : CAPTURE;
      default: begin
        state_n = vblank ? (continuous ? ARMED : IDLE) : PUBLISH;
        done = vblank && !reset;
      end
    endcase
  end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // edge history, shift register, sample count and published record
  always_ff @(posedge clk)
    if (reset) begin
      prev <= 1'b0;
      shreg <= '0;
      cnt <= '0;
      data <= '0;
    end else begin
      prev <= load || tick ? sig_s : prev;
      if (shift) shreg <= {sig_s, shreg[DATA_SIZE-1:1]};
      cnt <= !shift ? cnt : state == ARMED ? CW'(1) : cnt + CW'(1);
      if (done) data <= shreg;
    end
endmodule
